vert_avg_drain: RTL and testbench
=================================

Name: vert_avg_drain

Overview:
- Read-side companion to the vertical-average MAC. After all weighted input rows for one output row are accumulated into the 28-entry sum buffer, this block drains it.
- For each entry it reads the 24-bit fixed-point sum (8 fractional bits), rounds and saturates it to an 8-bit pixel, and emits it on a valid/ready byte stream with a last flag.
- It optionally writes zero back to each entry so the buffer is clear for the next row. It is started and completed by the resize FSM with the same req/ack handshake the MAC uses.

Parameters:
- NUM_PIX, 28, entries per row; indices 0..NUM_PIX-1.
- SUM_W, 24, sum buffer word width.
- FRAC_BITS, 8, fractional bits in each sum (weight 256 = 1.0).
- PIX_W, 8, output pixel width.

Ports:
- clk  input  1  clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- sum_raddr  output  5  sum buffer read address; combinational (same-cycle) read.
- sum_rdata  input  SUM_W  sum buffer read data for sum_raddr.
- sum_waddr  output  5  sum buffer write address.
- sum_wdata  output  SUM_W  write data; always 0.
- sum_we  output  1  write enable (clear strobe).
- clear_en  input  1  1 = zero each entry as it is drained; sampled on each load.
- req  input  1  drain request from FSM.
- ack  output  1  drain complete; held until req falls.
- out_data  output  PIX_W  output pixel.
- out_valid  output  1  out_data valid.
- out_last  output  1  marks pixel NUM_PIX-1.
- out_ready  input  1  downstream accept.

Behaviour:
- Reset values: ack=0, out_valid=0, out_last=0, out_data=0, sum_we=0, index=0, state=IDLE. sum_raddr=sum_waddr=index=0.
- States:
  - IDLE: when req=1 and ack=0, go to DRAIN with index=0.
  - DRAIN: streams pixels; on the handshake of the last beat (out_valid & out_ready & out_last), go to DONE and set ack=1.
  - DONE: ack=1. When req=0, go to IDLE and set ack=0 (visible the next cycle). While req stays 1, remain in DONE; there is no re-trigger.
- sum_raddr = index (combinational). Address width is 5 bits, so NUM_PIX must be ≤ 32.
- load = (state==DRAIN) & (index < NUM_PIX) & (~out_valid | out_ready).
- On a load:
  - out_data <= sat(round(sum_rdata)).
  - out_valid <= 1.
  - out_last <= (index==NUM_PIX-1).
  - index <= index+1.
  - In the same cycle, combinationally: sum_we = clear_en, sum_waddr = index, sum_wdata = 0.
- Read and clear hit the same address in the same cycle; the read value is the pre-clear value.
- If out_valid & out_ready and there is no load: out_valid <= 0 and out_last <= 0.
- Throughput is 1 pixel/cycle while out_ready=1. Latency from req rise to the first out_valid is 2 cycles (IDLE→DRAIN, then load).
- Backpressure: while out_valid=1 and out_ready=0, out_data, out_last and index hold, and sum_we=0.
- Arithmetic:
  - Compute r = {1'b0, sum_rdata} + 2^(FRAC_BITS-1) in SUM_W+1 bits.
  - p = r >> FRAC_BITS.
  - If p > 255, out_data = 255; otherwise out_data = p[7:0].
- Exactly NUM_PIX beats per request. out_last is asserted only with the final beat.
- req falling in DRAIN (abort):
  - Next cycle: state=IDLE, out_valid=0, out_last=0, index=0, ack stays 0.
  - Entries already cleared stay cleared; no further writes occur.
- ack is never asserted without all NUM_PIX beats having been accepted.
- Reset mid-operation: every register returns to its reset value on the next edge. sum_we is deasserted in the reset cycle.

Test Plan:
- Sums: entry i = i×256 (i = 0..27); clear_en=1; out_ready=1; pulse req → out_data = 0,1,…,27 on 28 consecutive cycles, out_last only on 27; ack rises the cycle after the last beat; every entry reads 0 afterwards.
- Rounding and saturation: entry0=0x00007F, entry1=0x000080, entry2=0x00FF7F, entry3=0x00FF80, entry4=0xFFFFFF → out_data = 0, 1, 255, 255 (saturated), 255.
- Backpressure: toggle out_ready 1,0,0,1,… randomly → 28 beats in index order with no duplicates or drops; out_data is stable while stalled; sum_we never asserts on a stall cycle.
- clear_en=0 → stream is identical to the first scenario and the buffer contents are unchanged afterwards.
- Abort: drop req after 10 accepted beats → out_valid=0 on the next cycle; ack is never 1; entries 0–9 are zero and entries 10–27 are intact. A new req restarts at index 0.
- Handshake: hold req high after ack → ack stays 1 and there is no second drain. Lower req → ack=0 on the next cycle. Assert reset during DRAIN → all outputs return to reset values on the next edge.

Source files
------------

// File: rtl/vert_avg_drain.sv
// ----------------------------------------------------------------------------
// vert_avg_drain
//
// Drains the vertical-average sum buffer after one output row has been
// accumulated. Each 24-bit fixed-point sum (FRAC_BITS fractional bits) is
// rounded to nearest, saturated to an 8-bit pixel and sent out on a
// valid/ready byte stream. The entry can optionally be zeroed as it is read,
// which leaves the buffer clear for the next row. The drain is started and
// finished with the same req/ack handshake that the MAC uses.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   sum_raddr  sum buffer read address (the read is combinational)
//   sum_rdata  sum buffer read data for sum_raddr
//   sum_waddr  sum buffer write address (same entry as the read)
//   sum_wdata  sum buffer write data, always zero
//   sum_we     clear strobe, one pulse per loaded entry when clear_en=1
//   clear_en   1 = zero each entry as it is drained
//   req        drain request from the resize FSM
//   ack        drain complete; held until req falls
//   out_data   output pixel
//   out_valid  out_data is valid
//   out_last   marks pixel NUM_PIX-1
//   out_ready  downstream accept
// ----------------------------------------------------------------------------
module vert_avg_drain #(
    parameter int NUM_PIX   = 28,
    parameter int SUM_W     = 24,
    parameter int FRAC_BITS = 8,
    parameter int PIX_W     = 8
) (
    input  logic             clk,
    input  logic             reset,
    output logic [4:0]       sum_raddr,
    input  logic [SUM_W-1:0] sum_rdata,
    output logic [4:0]       sum_waddr,
    output logic [SUM_W-1:0] sum_wdata,
    output logic             sum_we,
    input  logic             clear_en,
    input  logic             req,
    output logic             ack,
    output logic [PIX_W-1:0] out_data,
    output logic             out_valid,
    output logic             out_last,
    input  logic             out_ready
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state, state_next;
    logic             ack_next;
    logic [5:0]       index;      // one bit wider than the address so it can reach NUM_PIX
    logic             load;
    logic             accept;
    logic [SUM_W:0]   rounded;
    logic [SUM_W:0]   scaled;
    logic [PIX_W-1:0] pix;

    // A new entry is fetched whenever the output register is empty or is
    // being emptied this cycle. Qualifying with req means the cycle in which
    // req drops performs neither a fetch nor a clear.
    assign load   = !reset && (state == DRAIN) && req &&
                    (index < 6'(NUM_PIX)) && (!out_valid || out_ready);
    assign accept = out_valid && out_ready;

    // Read and clear address the same entry; the read returns the pre-clear
    // value because the write only lands on the next edge.
    assign sum_raddr = index[4:0];
    assign sum_waddr = index[4:0];
    assign sum_wdata = '0;
    assign sum_we    = load && clear_en;

    // Round to nearest (add half an LSB), drop fraction, saturate to PIX_W.
    assign rounded = {1'b0, sum_rdata} + (SUM_W+1)'(1 << (FRAC_BITS - 1));
    assign scaled  = rounded >> FRAC_BITS;
    assign pix     = (scaled > (SUM_W+1)'((1 << PIX_W) - 1)) ? '1 : scaled[PIX_W-1:0];

    always_comb begin
        // NOTE: every signal driven here gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        state_next = state;
        ack_next   = ack;
        case (state)
            IDLE: begin
                if (req && !ack) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (!req) begin
                    state_next = IDLE;            // abort: no ack
                end else if (accept && out_last) begin
                    state_next = DONE;
                    ack_next   = 1'b1;
                end
            end
            DONE: begin
                if (!req) begin
                    state_next = IDLE;
                    ack_next   = 1'b0;
                end
            end
            default: begin
                state_next = IDLE;
                ack_next   = 1'b0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            ack       <= 1'b0;
            index     <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            state <= state_next;
            ack   <= ack_next;
            if (state == IDLE) begin
                index <= '0;
            end else if (state == DRAIN && !req) begin
                index     <= '0;
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end else if (load) begin
                out_data  <= pix;
                out_valid <= 1'b1;
                out_last  <= (index == 6'(NUM_PIX - 1));
                index     <= index + 6'd1;
            end else if (accept) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_vert_avg_drain.sv
// ----------------------------------------------------------------------------
// tb_vert_avg_drain
//
// Directed bench for vert_avg_drain. A behavioural 28-entry sum buffer with a
// combinational read and a clocked write sits beside the DUT. Inputs change
// 2 time units after the rising edge; the monitor samples at the falling edge.
// ----------------------------------------------------------------------------
module tb_vert_avg_drain;

    localparam int NUM_PIX = 28;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  sum_raddr;
    logic [23:0] sum_rdata;
    logic [4:0]  sum_waddr;
    logic [23:0] sum_wdata;
    logic        sum_we;
    logic        clear_en;
    logic        req;
    logic        ack;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_last;
    logic        out_ready;

    logic [23:0] mem [NUM_PIX];

    int total = 0;
    int bad   = 0;

    // Monitor results
    logic [7:0] beats[$];
    logic       lasts[$];
    int         stall_we_err   = 0;
    int         stall_data_err = 0;
    int         ack_seen       = 0;
    bit         stalled_prev   = 1'b0;
    logic [7:0] prev_data      = 8'd0;

    always #5 clk = ~clk;

    vert_avg_drain dut (
        .clk       (clk),
        .reset     (reset),
        .sum_raddr (sum_raddr),
        .sum_rdata (sum_rdata),
        .sum_waddr (sum_waddr),
        .sum_wdata (sum_wdata),
        .sum_we    (sum_we),
        .clear_en  (clear_en),
        .req       (req),
        .ack       (ack),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_last  (out_last),
        .out_ready (out_ready)
    );

    assign sum_rdata = (sum_raddr < 5'(NUM_PIX)) ? mem[sum_raddr] : 24'd0;

    always @(posedge clk) begin
        if (sum_we && sum_waddr < 5'(NUM_PIX)) mem[sum_waddr] <= sum_wdata;
    end

    always @(negedge clk) begin
        if (reset) begin
            stalled_prev = 1'b0;
        end else begin
            if (out_valid && out_ready) begin
                beats.push_back(out_data);
                lasts.push_back(out_last);
            end
            if (out_valid && !out_ready && sum_we) stall_we_err++;
            if (stalled_prev && out_data !== prev_data) stall_data_err++;
            stalled_prev = out_valid && !out_ready;
            prev_data    = out_data;
            if (ack) ack_seen++;
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic fill_ramp();
        for (int i = 0; i < NUM_PIX; i++) mem[i] = 24'(i * 256);
    endtask

    // Runs until ack appears; reports the gap between the last beat and ack.
    task automatic run_until_ack(input bit rnd, output int gap);
        int last_cyc = -1;
        int ack_cyc  = -1;
        for (int c = 0; c < 400 && ack_cyc < 0; c++) begin
            step();
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (out_valid && out_ready && out_last) last_cyc = c;
            if (ack) ack_cyc = c;
        end
        total++;
        if (ack_cyc < 0) begin
            bad++;
            $display("FAIL ack_timeout: ack never rose, required within 400 cycles");
        end
        gap = ack_cyc - last_cyc;
    endtask

    task automatic check_ramp_stream(input string name);
        total++;
        if (beats.size() != NUM_PIX) begin
            bad++;
            $display("FAIL %s_count: got %0d beats, expected %0d", name, beats.size(), NUM_PIX);
        end else begin
            for (int i = 0; i < NUM_PIX; i++) begin
                total++;
                if (beats[i] !== 8'(i) || lasts[i] !== (i == NUM_PIX - 1)) begin
                    bad++;
                    $display("FAIL %s_beat%0d: data=%0d last=%0b expected data=%0d last=%0b",
                             name, i, beats[i], lasts[i], i, (i == NUM_PIX - 1));
                end
            end
        end
    endtask

    task automatic finish_handshake(input string name);
        req = 1'b0;
        step();
        total++;
        if (ack !== 1'b0) begin
            bad++;
            $display("FAIL %s_ack_drop: ack=%0b expected 0", name, ack);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; req = 1'b0; clear_en = 1'b0; out_ready = 1'b1;
        step(); step();
        total++;
        if ({ack, out_valid, out_last, out_data, sum_we, sum_raddr, sum_waddr} !== 18'd0) begin
            bad++;
            $display("FAIL reset_outputs: ack=%0b v=%0b l=%0b d=%0d we=%0b ra=%0d wa=%0d expected all 0",
                     ack, out_valid, out_last, out_data, sum_we, sum_raddr, sum_waddr);
        end
        total++;
        if (sum_wdata !== 24'd0) begin
            bad++;
            $display("FAIL reset_wdata: got %0h expected 0", sum_wdata);
        end
        reset = 1'b0;
        step();
    endtask

    task automatic test_stream();
        int gap;
        int snap;
        fill_ramp();
        clear_en = 1'b1; out_ready = 1'b1;
        beats.delete(); lasts.delete();
        req = 1'b1;
        step();
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL latency_early: out_valid=%0b one cycle after req, expected 0", out_valid);
        end
        step();
        total++;
        if (out_valid !== 1'b1 || out_data !== 8'd0) begin
            bad++;
            $display("FAIL latency_first: valid=%0b data=%0d two cycles after req, expected 1/0",
                     out_valid, out_data);
        end
        run_until_ack(1'b0, gap);
        total++;
        if (gap != 1) begin
            bad++;
            $display("FAIL ack_gap: ack came %0d cycles after last beat, expected 1", gap);
        end
        check_ramp_stream("stream");
        // Hold req: ack stays, no second drain.
        snap = beats.size();
        for (int i = 0; i < 6; i++) step();
        total++;
        if (ack !== 1'b1 || out_valid !== 1'b0 || beats.size() != snap) begin
            bad++;
            $display("FAIL hold_req: ack=%0b valid=%0b beats=%0d expected 1/0/%0d",
                     ack, out_valid, beats.size(), snap);
        end
        finish_handshake("stream");
        for (int i = 0; i < NUM_PIX; i++) begin
            total++;
            if (mem[i] !== 24'd0) begin
                bad++;
                $display("FAIL stream_cleared%0d: mem=%0h expected 0", i, mem[i]);
            end
        end
    endtask

    task automatic test_rounding();
        int gap;
        logic [7:0] exp_pix [5];
        exp_pix = '{8'd0, 8'd1, 8'd255, 8'd255, 8'd255};
        for (int i = 0; i < NUM_PIX; i++) mem[i] = 24'd0;
        mem[0] = 24'h00007F; mem[1] = 24'h000080; mem[2] = 24'h00FF7F;
        mem[3] = 24'h00FF80; mem[4] = 24'hFFFFFF;
        clear_en = 1'b1; out_ready = 1'b1;
        beats.delete(); lasts.delete();
        req = 1'b1;
        run_until_ack(1'b0, gap);
        for (int i = 0; i < 5; i++) begin
            total++;
            if (beats.size() <= i || beats[i] !== exp_pix[i]) begin
                bad++;
                $display("FAIL round_sat%0d: got %0d expected %0d",
                         i, (beats.size() > i) ? beats[i] : 8'hxx, exp_pix[i]);
            end
        end
        finish_handshake("round");
    endtask

    task automatic test_backpressure();
        int gap;
        fill_ramp();
        clear_en = 1'b1;
        beats.delete(); lasts.delete();
        stall_we_err = 0; stall_data_err = 0;
        req = 1'b1; out_ready = 1'b1;
        step(); out_ready = 1'b0;
        step(); out_ready = 1'b0;
        step(); out_ready = 1'b1;
        run_until_ack(1'b1, gap);
        check_ramp_stream("bp");
        total++;
        if (stall_we_err != 0) begin
            bad++;
            $display("FAIL bp_we_on_stall: %0d stall cycles with sum_we=1, expected 0", stall_we_err);
        end
        total++;
        if (stall_data_err != 0) begin
            bad++;
            $display("FAIL bp_data_stable: %0d stall cycles changed out_data, expected 0", stall_data_err);
        end
        out_ready = 1'b1;
        finish_handshake("bp");
    endtask

    task automatic test_no_clear();
        int gap;
        fill_ramp();
        clear_en = 1'b0; out_ready = 1'b1;
        beats.delete(); lasts.delete();
        req = 1'b1;
        run_until_ack(1'b0, gap);
        check_ramp_stream("noclr");
        finish_handshake("noclr");
        for (int i = 0; i < NUM_PIX; i++) begin
            total++;
            if (mem[i] !== 24'(i * 256)) begin
                bad++;
                $display("FAIL noclr_kept%0d: mem=%0h expected %0h", i, mem[i], 24'(i * 256));
            end
        end
    endtask

    task automatic test_abort();
        int ack_before;
        int gap;
        bit dropped = 1'b0;
        fill_ramp();
        clear_en = 1'b1; out_ready = 1'b1;
        beats.delete(); lasts.delete();
        ack_before = ack_seen;
        req = 1'b1;
        for (int c = 0; c < 100 && !dropped; c++) begin
            step();
            if (out_valid && out_data == 8'd9) begin
                req = 1'b0;       // beat 9 is accepted in this cycle
                dropped = 1'b1;
            end
        end
        step();
        total++;
        if (out_valid !== 1'b0 || out_last !== 1'b0 || sum_raddr !== 5'd0) begin
            bad++;
            $display("FAIL abort_outputs: valid=%0b last=%0b raddr=%0d expected 0/0/0",
                     out_valid, out_last, sum_raddr);
        end
        for (int i = 0; i < 4; i++) step();
        total++;
        if (beats.size() != 10 || ack_seen != ack_before) begin
            bad++;
            $display("FAIL abort_beats_ack: beats=%0d ack_cycles=%0d expected 10/0",
                     beats.size(), ack_seen - ack_before);
        end
        for (int i = 0; i < NUM_PIX; i++) begin
            total++;
            if (mem[i] !== ((i < 10) ? 24'd0 : 24'(i * 256))) begin
                bad++;
                $display("FAIL abort_mem%0d: mem=%0h expected %0h",
                         i, mem[i], (i < 10) ? 24'd0 : 24'(i * 256));
            end
        end
        // Restart: begins at index 0 and delivers all 28 beats.
        beats.delete(); lasts.delete();
        req = 1'b1;
        run_until_ack(1'b0, gap);
        total++;
        if (beats.size() != NUM_PIX || beats[0] !== 8'd0 || beats[10] !== 8'd10 ||
            beats[27] !== 8'd27 || lasts[27] !== 1'b1) begin
            bad++;
            $display("FAIL abort_restart: beats=%0d b10=%0d b27=%0d expected 28/10/27",
                     beats.size(), (beats.size() > 10) ? beats[10] : 8'hxx,
                     (beats.size() > 27) ? beats[27] : 8'hxx);
        end
        finish_handshake("restart");
    endtask

    task automatic test_reset_mid();
        fill_ramp();
        clear_en = 1'b1; out_ready = 1'b1;
        req = 1'b1;
        for (int i = 0; i < 6; i++) step();
        reset = 1'b1;
        #1;
        total++;
        if (sum_we !== 1'b0) begin
            bad++;
            $display("FAIL rst_mid_we: sum_we=%0b during reset cycle, expected 0", sum_we);
        end
        step();
        total++;
        if ({ack, out_valid, out_last, out_data, sum_we, sum_raddr, sum_waddr} !== 18'd0) begin
            bad++;
            $display("FAIL rst_mid_outputs: ack=%0b v=%0b l=%0b d=%0d we=%0b ra=%0d expected all 0",
                     ack, out_valid, out_last, out_data, sum_we, sum_raddr);
        end
        req = 1'b0;
        reset = 1'b0;
        step();
    endtask

    initial begin
        for (int i = 0; i < NUM_PIX; i++) mem[i] = 24'd0;
        test_reset();
        test_stream();
        test_rounding();
        test_backpressure();
        test_no_clear();
        test_abort();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
